// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS core types, constants and instruction field
//               positions.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] instr_t;

    localparam instr_t NOP = '0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    // Fetch addresses are always word-aligned; low two bits are discarded.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold, flush and load controls,
//               a valid bit and asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_hold,
    input  logic            i_flush,
    input  logic            i_load,
    input  instr_t          i_instr,
    input  logic [XLEN-1:0] i_pc4,
    output instr_t          o_instr,
    output logic [XLEN-1:0] o_pc4,
    output logic            o_valid
);

    instr_t          r_instr;
    logic [XLEN-1:0] r_pc4;
    logic            r_valid;

    // Hold dominates flush, which dominates load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_instr <= r_instr;
            r_pc4   <= r_pc4;
            r_valid <= r_valid;
        end else if (i_flush) begin
            r_instr <= NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : MIPS instruction-fetch stage: PC, redirect mux, IF/ID register
//               and retired-fetch counter. Macro BRANCH_DELAY_SLOT_EN keeps
//               the instruction after a redirect (delay slot) instead of
//               flushing it.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] fetch_count
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_count;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic            w_flush;
    logic            w_load;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redirect = (jump | branch_taken) & ~stall;
    assign w_target   = align_word(jump ? jump_target : branch_target);

`ifdef BRANCH_DELAY_SLOT_EN
    assign w_flush = 1'b0;
    assign w_load  = ~stall;
`else
    assign w_flush = w_redirect;
    assign w_load  = ~stall & ~w_redirect;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            if (!stall) begin
                r_pc <= w_redirect ? w_target : w_pc4;
            end
            if (w_load) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (stall),
        .i_flush (w_flush),
        .i_load  (w_load),
        .i_instr (imem_rdata),
        .i_pc4   (w_pc4),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign fetch_count = r_fetch_count;
    assign rs          = if_id_instr[RS_HI:RS_LO];
    assign rt          = if_id_instr[RT_HI:RT_LO];
    assign rd          = if_id_instr[RD_HI:RD_LO];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed vector table,
//               hand-written reset/wrap sequences and randomized traffic
//               against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .fetch_count   (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A4_2020;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of the fetch stage state.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    task automatic model_reset();
        m_pc = 32'h100; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (stall) return;
        if (jump || branch_taken) begin
            tgt = jump ? jump_target : branch_target;
            tgt[1:0] = 2'b00;
            if (D == 1) begin
                m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end else begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end
            m_pc = tgt;
        end else begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    imem_addr,   m_pc);
        chk({tag, ".instr"}, if_id_instr, m_instr);
        chk({tag, ".pc4"},   if_id_pc4,   m_pc4);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
        chk({tag, ".rs"},    {27'b0, rs}, {27'b0, m_instr[25:21]});
        chk({tag, ".rt"},    {27'b0, rt}, {27'b0, m_instr[20:16]});
        chk({tag, ".rd"},    {27'b0, rd}, {27'b0, m_instr[15:11]});
        chk({tag, ".count"}, fetch_count, m_cnt);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        valid;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic [31:0] pc,
                                input logic [31:0] pc4, input int cnt, input logic v);
        vec_t r;
        r.stall = s; r.br = b; r.bt = bt; r.jmp = j; r.jt = jt;
        r.pc = pc; r.pc4 = pc4; r.cnt = 32'(cnt); r.valid = v;
        return r;
    endfunction

    initial begin
        logic dl;
        dl = (D == 1);
        tbl[0]  = mk(0, 0, 0,        0, 0,        32'h104, 32'h104,          1,       1'b1);
        tbl[1]  = mk(0, 0, 0,        1, 32'h0,    32'h0,   dl ? 32'h108 : 0, 1 + D,   dl);
        tbl[2]  = mk(0, 0, 0,        0, 0,        32'h4,   32'h4,            2 + D,   1'b1);
        tbl[3]  = mk(0, 0, 0,        0, 0,        32'h8,   32'h8,            3 + D,   1'b1);
        tbl[4]  = mk(1, 0, 0,        0, 0,        32'h8,   32'h8,            3 + D,   1'b1);
        tbl[5]  = mk(1, 1, 32'h300,  0, 0,        32'h8,   32'h8,            3 + D,   1'b1);
        tbl[6]  = mk(1, 0, 0,        0, 0,        32'h8,   32'h8,            3 + D,   1'b1);
        tbl[7]  = mk(0, 0, 0,        0, 0,        32'hC,   32'hC,            4 + D,   1'b1);
        tbl[8]  = mk(0, 0, 0,        0, 0,        32'h10,  32'h10,           5 + D,   1'b1);
        tbl[9]  = mk(0, 1, 32'h203,  0, 0,        32'h200, dl ? 32'h14 : 0,  5 + 2*D, dl);
        tbl[10] = mk(0, 1, 32'h80,   1, 32'h40,   32'h40,  dl ? 32'h204 : 0, 5 + 3*D, dl);
        tbl[11] = mk(0, 0, 0,        0, 0,        32'h44,  32'h44,           6 + 3*D, 1'b1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].jmp, tbl[i].jt);
            step();
            chk($sformatf("vec%0d.pc", i),    imem_addr,   tbl[i].pc);
            chk($sformatf("vec%0d.pc4", i),   if_id_pc4,   tbl[i].pc4);
            chk($sformatf("vec%0d.count", i), fetch_count, tbl[i].cnt);
            chk($sformatf("vec%0d.valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].valid});
            check_model($sformatf("vec%0d", i));
            if (i == 0) begin
                chk("first.instr", if_id_instr, 32'h00A4_2020);
                chk("first.rs", {27'b0, rs}, 32'd5);
                chk("first.rt", {27'b0, rt}, 32'd4);
                chk("first.rd", {27'b0, rd}, 32'd4);
            end
        end
        drive(0, 0, 0, 0, 0);

        // Asynchronous reset between edges must act immediately.
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // PC wrap at the top of the address space.
        drive(0, 0, 0, 1, 32'hFFFF_FFFD);
        step();
        chk("wrap.jmp.pc", imem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0);
        step();
        chk("wrap.pc", imem_addr, 32'h0);
        chk("wrap.pc4", if_id_pc4, 32'h0);
        check_model("wrap");

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3, 0) == 0, $urandom_range(4, 0) == 0, $urandom(),
                  $urandom_range(6, 0) == 0, $urandom());
            step();
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
